// File: rtl/tx_arbiter.sv
// Round-robin arbiter that frames packets from N_SRC show-ahead FIFOs onto one
// UART byte stream: PREFIX, SRC, DEST, LEN, payload, CRC-8 (poly 0x07).
module tx_arbiter #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] PREFIX    = 8'hDD,
  parameter logic [7:0] DEST_ADDR = 8'h01,
  parameter logic [7:0] SRC_BASE  = 8'h02
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [8*N_SRC-1:0] src_len,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_rdreq,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [N_SRC-1:0]   grant,
  output logic               busy
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_SRC,
    ST_DEST,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gidx;
  logic [7:0]    len_q;
  logic [7:0]    cnt;
  logic [7:0]    crc;
  logic [7:0]    hdr;

  logic          hs;
  logic          win_found;
  logic [IW-1:0] win_idx;
  int            cand;
  logic [7:0]    pay_byte;
  logic [7:0]    crc_upd;
  logic [7:0]    cnt_next;
  logic [IW-1:0] rr_next;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int b = 0; b < 8; b++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = (int'(rr_ptr) + k) % N_SRC;
      if (!win_found && src_req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // Payload comes straight from the show-ahead FIFO head; header/CRC bytes are registered.
  assign pay_byte  = src_data[8*gidx +: 8];
  assign tx_data   = (state == ST_PAYLOAD) ? pay_byte : hdr;
  assign hs        = tx_valid && tx_ready;
  assign src_rdreq = (!rst && hs && state == ST_PAYLOAD) ? grant : '0;
  assign crc_upd   = crc8_step(crc, tx_data);
  assign cnt_next  = cnt + 8'd1;
  assign rr_next   = (gidx == IW'(N_SRC - 1)) ? '0 : gidx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      hdr      <= 8'h00;
      grant    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      gidx     <= '0;
      len_q    <= 8'h00;
      cnt      <= 8'h00;
      crc      <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            grant    <= N_SRC'(1) << win_idx;
            gidx     <= win_idx;
            len_q    <= src_len[8*win_idx +: 8];
            cnt      <= 8'h00;
            crc      <= 8'h00;
            hdr      <= PREFIX;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_PREFIX;
          end
        end
        ST_PREFIX: begin
          if (hs) begin
            hdr   <= SRC_BASE + 8'(gidx);
            state <= ST_SRC;
          end
        end
        ST_SRC: begin
          if (hs) begin
            crc   <= crc_upd;
            hdr   <= DEST_ADDR;
            state <= ST_DEST;
          end
        end
        ST_DEST: begin
          if (hs) begin
            crc   <= crc_upd;
            hdr   <= len_q;
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (hs) begin
            crc <= crc_upd;
            if (len_q == 8'h00) begin
              hdr   <= crc_upd;
              state <= ST_CRC;
            end else begin
              cnt   <= 8'h00;
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (hs) begin
            crc <= crc_upd;
            cnt <= cnt_next;
            if (cnt_next == len_q) begin
              hdr   <= crc_upd;
              state <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (hs) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            grant    <= '0;
            hdr      <= 8'h00;
            rr_ptr   <= rr_next;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: framing, CRC, round-robin fairness,
// backpressure, mid-packet reset and ignored request changes.
module tb_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_req;
  logic [8*N-1:0] src_len;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_rdreq;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Show-ahead source FIFO model: head advances on each src_rdreq pulse.
  logic [7:0]  fifo [N][8];
  int unsigned rd_ptr [N] = '{default: 0};
  int unsigned base   [N] = '{default: 0};

  logic [7:0]     got [$];
  logic [7:0]     exp_q [$];
  int             rd_pulses;
  int             rd_bad;
  int             grant_bad;
  logic [N-1:0]   grant_seen;

  tx_arbiter #(.N_SRC(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_req  (src_req),
    .src_len  (src_len),
    .src_data (src_data),
    .src_rdreq(src_rdreq),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (src_rdreq[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_data[8*i +: 8] = fifo[i][3'(rd_ptr[i] - base[i])];
    end
  end

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int b = 0; b < 8; b++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [7:0] len,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int k = 0; k < 8; k++) fifo[idx][k] = 8'h00;
    fifo[idx][0] = b0;
    fifo[idx][1] = b1;
    fifo[idx][2] = b2;
    base[idx] = rd_ptr[idx];
    src_len[8*idx +: 8] = len;
  endtask

  task automatic build(input int idx, input int len, input int off);
    logic [7:0] c;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hDD);
    exp_q.push_back(8'h02 + 8'(idx));
    exp_q.push_back(8'h01);
    exp_q.push_back(8'(len));
    c = 8'h00;
    for (int k = 1; k < 4; k++) c = crc8(c, exp_q[k]);
    for (int k = 0; k < len; k++) begin
      b = fifo[idx][off + k];
      exp_q.push_back(b);
      c = crc8(c, b);
    end
    exp_q.push_back(c);
  endtask

  task automatic check_pkt(input string tag);
    chk({tag, " length"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s byte%0d", tag, i), got[i], exp_q[i]);
    end
  endtask

  // Collects transferred bytes until nbytes have been handed over. Optionally
  // stalls tx_ready for 5 cycles before byte stall_at, and drops the request
  // (with a bogus length) before byte drop_at.
  task automatic collect(input int nbytes, input int plen, input int stall_at,
                         input logic [7:0] stall_byte, input int drop_at);
    int budget;
    int stall_left;
    bit payload;
    got.delete();
    rd_pulses  = 0;
    rd_bad     = 0;
    grant_bad  = 0;
    grant_seen = '0;
    budget     = 0;
    stall_left = 5;
    while (got.size() < nbytes && budget < 300) begin
      @(negedge clk);
      budget++;
      if (got.size() == drop_at) begin
        src_req = '0;
        src_len = {N{8'h7F}};
      end
      tx_ready = !(got.size() == stall_at && stall_left > 0);
      #1;
      if (!tx_ready) begin
        stall_left--;
        chk("stall tx_valid", tx_valid, 1'b1);
        chk("stall tx_data", tx_data, stall_byte);
        chk("stall src_rdreq", src_rdreq, '0);
      end
      if (tx_valid && tx_ready) begin
        if (got.size() == 0) grant_seen = grant;
        else if (grant !== grant_seen) grant_bad++;
        payload = (got.size() >= 4) && (got.size() < 4 + plen);
        if (src_rdreq !== (payload ? grant : '0)) rd_bad++;
        if (payload && src_rdreq != '0) rd_pulses++;
        got.push_back(tx_data);
      end else if (src_rdreq !== '0) begin
        rd_bad++;
      end
    end
    if (budget >= 300) chk("timeout bytes", got.size(), nbytes);
    @(posedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    tx_ready = 1'b1;
    src_req  = '1;
    src_len  = '0;
    for (int i = 0; i < N; i++) load(i, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset grant", grant, '0);
    chk("reset busy", busy, 1'b0);
    chk("reset src_rdreq", src_rdreq, '0);
    src_req = '0;
    rst     = 1'b0;
    @(negedge clk);

    // Basic packet with one-cycle start latency
    load(0, 8'h01, 8'hAA, 8'h55, 8'h00);
    src_req = 4'b0001;
    @(posedge clk);
    #1;
    chk("latency tx_valid", tx_valid, 1'b1);
    chk("latency tx_data", tx_data, 8'hDD);
    chk("latency grant", grant, 4'b0001);
    chk("latency busy", busy, 1'b1);
    exp_q = '{8'hDD, 8'h02, 8'h01, 8'h01, 8'hAA, 8'h0D};
    collect(6, 1, -1, 8'h00, -1);
    check_pkt("basic");
    chk("basic rdreq pulses", rd_pulses, 1);
    chk("basic rdreq misplaced", rd_bad, 0);
    @(negedge clk);
    chk("post tx_valid", tx_valid, 1'b0);
    chk("post busy", busy, 1'b0);
    chk("post grant", grant, '0);
    chk("post tx_data", tx_data, 8'h00);
    src_req = '0;

    // Zero-length packet; rr_ptr=1 must wrap round to source 0
    load(0, 8'h00, 8'h00, 8'h00, 8'h00);
    src_req = 4'b0001;
    exp_q = '{8'hDD, 8'h02, 8'h01, 8'h00, 8'hC3};
    collect(5, 0, -1, 8'h00, -1);
    check_pkt("zero");
    chk("zero rdreq pulses", rd_pulses, 0);
    chk("zero rdreq misplaced", rd_bad, 0);
    @(negedge clk);
    src_req = '0;

    // Fairness: sources 0 and 2 requesting from reset
    rst = 1'b1;
    load(0, 8'h01, 8'hA0, 8'hA1, 8'h00);
    load(2, 8'h01, 8'hC0, 8'hC1, 8'h00);
    src_req = 4'b0101;
    @(negedge clk);
    chk("fair reset src_rdreq", src_rdreq, '0);
    chk("fair reset tx_valid", tx_valid, 1'b0);
    rst = 1'b0;
    for (int p = 0; p < 4; p++) begin
      build((p % 2 == 0) ? 0 : 2, 1, p / 2);
      collect(6, 1, -1, 8'h00, -1);
      check_pkt($sformatf("fair%0d", p));
      chk($sformatf("fair%0d grant", p), grant_seen, (p % 2 == 0) ? 4'b0001 : 4'b0100);
      chk($sformatf("fair%0d grant stable", p), grant_bad, 0);
      chk($sformatf("fair%0d rdreq misplaced", p), rd_bad, 0);
      @(negedge clk);
      chk($sformatf("fair%0d idle gap", p), tx_valid, 1'b0);
    end
    src_req = '0;

    // Backpressure during payload
    load(1, 8'h02, 8'h11, 8'h22, 8'h00);
    build(1, 2, 0);
    src_req = 4'b0010;
    collect(7, 2, 5, 8'h22, -1);
    check_pkt("bp");
    chk("bp grant", grant_seen, 4'b0010);
    chk("bp rdreq pulses", rd_pulses, 2);
    chk("bp rdreq misplaced", rd_bad, 0);
    @(negedge clk);
    src_req = '0;

    // Reset mid-payload
    load(0, 8'h03, 8'h31, 8'h32, 8'h33);
    src_req = 4'b0001;
    collect(5, 3, -1, 8'h00, -1);
    chk("mid rdreq pulses", rd_pulses, 1);
    @(negedge clk);
    rst     = 1'b1;
    src_req = 4'b0010;
    #1;
    chk("mid rst src_rdreq", src_rdreq, '0);
    @(negedge clk);
    chk("mid after tx_valid", tx_valid, 1'b0);
    chk("mid after busy", busy, 1'b0);
    chk("mid after grant", grant, '0);
    chk("mid src0 pops", rd_ptr[0] - base[0], 1);
    rst = 1'b0;
    load(1, 8'h00, 8'h00, 8'h00, 8'h00);
    build(1, 0, 0);
    collect(5, 0, -1, 8'h00, -1);
    check_pkt("mid next");
    chk("mid next grant", grant_seen, 4'b0010);
    @(negedge clk);
    src_req = '0;

    // Request and length change during LEN are ignored
    load(0, 8'h02, 8'h41, 8'h42, 8'h00);
    build(0, 2, 0);
    src_req = 4'b0001;
    collect(7, 2, -1, 8'h00, 3);
    check_pkt("drop");
    chk("drop rdreq pulses", rd_pulses, 2);
    chk("drop rdreq misplaced", rd_bad, 0);
    @(negedge clk);
    chk("drop idle busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
